// File: rtl/controller.sv
// -----------------------------------------------------------------------------
// controller
// Multi-cycle Moore control unit for the lab CPU. It steps an instruction
// through fetch, decode, execute, memory and write-back phases based on a
// 3-bit opcode, and drives the datapath enable and select lines.
//
// State table:
//   state  | meaning
//   FETCH  | read instruction into IR, PC <= PC+1
//   DECODE | latch opcode, choose the next phase
//   EXEC   | ALU operation, address calculation, branch compare or jump
//   MEM    | data memory read (LOAD) or write (STORE)
//   WB     | register file write-back
//   HALT   | stopped; only reset leaves this state
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   code[2:0]  in   opcode from the instruction register, sampled in DECODE
//   state[2:0] out  current FSM state
//   pc_write, ir_write, mem_read, mem_write, reg_write          out  enables
//   alu_src, alu_op[1:0], mem_to_reg, reg_dst                   out  selects
//   branch, jump                                                out  PC control
//   halted                                                      out  in HALT
// -----------------------------------------------------------------------------
module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code,
    output logic [2:0] state,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       alu_src,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       branch,
    output logic       jump,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_ALU    = 3'd0;
    localparam logic [2:0] OP_ALUI   = 3'd1;
    localparam logic [2:0] OP_LOAD   = 3'd2;
    localparam logic [2:0] OP_STORE  = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;
    localparam logic [2:0] OP_JUMP   = 3'd5;
    localparam logic [2:0] OP_NOP    = 3'd6;
    localparam logic [2:0] OP_HALT   = 3'd7;

    state_t     r_state;
    logic [2:0] r_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_op    <= OP_NOP;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_op <= code;
                    case (code)
                        OP_HALT: r_state <= S_HALT;
                        OP_NOP:  r_state <= S_FETCH;
                        default: r_state <= S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ALU, OP_ALUI:   r_state <= S_WB;
                        OP_LOAD, OP_STORE: r_state <= S_MEM;
                        default:           r_state <= S_FETCH;
                    endcase
                end
                S_MEM:   r_state <= (r_op == OP_LOAD) ? S_WB : S_FETCH;
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                // Encodings 6 and 7 are unreachable; recover if ever seen.
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign state = r_state;

    // Outputs depend only on the state and the latched opcode; reset gates
    // them off combinationally so the datapath sees no strobes while held.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    ir_write = 1'b1;
                    mem_read = 1'b1;
                    pc_write = 1'b1;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ALU:  alu_op = 2'b10;
                        OP_ALUI, OP_LOAD, OP_STORE: alu_src = 1'b1;
                        OP_BRANCH: begin
                            alu_op = 2'b01;
                            branch = 1'b1;
                        end
                        OP_JUMP: begin
                            jump     = 1'b1;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_read  = (r_op == OP_LOAD);
                    mem_write = (r_op == OP_STORE);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (r_op == OP_LOAD);
                    reg_dst    = (r_op == OP_ALU);
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
module tb_controller;

    logic       clk;
    logic       rst;
    logic [2:0] code;
    logic [2:0] state;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, alu_src;
    logic [1:0] alu_op;
    logic       mem_to_reg, reg_dst, branch, jump, halted;

    int n_vec = 0;
    int n_err = 0;

    // Control word: {pc_write, ir_write, mem_read, mem_write, reg_write,
    //                alu_src, alu_op[1:0], mem_to_reg, reg_dst, branch, jump, halted}
    localparam logic [12:0] C_NONE    = 13'b0_0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_FETCH   = 13'b1_1_1_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_EX_ALU  = 13'b0_0_0_0_0_0_10_0_0_0_0_0;
    localparam logic [12:0] C_EX_IMM  = 13'b0_0_0_0_0_1_00_0_0_0_0_0;
    localparam logic [12:0] C_EX_BR   = 13'b0_0_0_0_0_0_01_0_0_1_0_0;
    localparam logic [12:0] C_EX_JMP  = 13'b1_0_0_0_0_0_00_0_0_0_1_0;
    localparam logic [12:0] C_MEM_LD  = 13'b0_0_1_0_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_MEM_ST  = 13'b0_0_0_1_0_0_00_0_0_0_0_0;
    localparam logic [12:0] C_WB_ALU  = 13'b0_0_0_0_1_0_00_0_1_0_0_0;
    localparam logic [12:0] C_WB_IMM  = 13'b0_0_0_0_1_0_00_0_0_0_0_0;
    localparam logic [12:0] C_WB_LD   = 13'b0_0_0_0_1_0_00_1_0_0_0_0;
    localparam logic [12:0] C_HALT    = 13'b0_0_0_0_0_0_00_0_0_0_0_1;

    controller dut (
        .clk        (clk),
        .rst        (rst),
        .code       (code),
        .state      (state),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .branch     (branch),
        .jump       (jump),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [12:0] ctl;
    assign ctl = {pc_write, ir_write, mem_read, mem_write, reg_write, alu_src,
                  alu_op, mem_to_reg, reg_dst, branch, jump, halted};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] es, input logic [12:0] ec);
        n_vec++;
        assert ({state, ctl} === {es, ec}) else begin
            n_err++;
            $error("FAIL %s: got state=%0d ctl=%b, expected state=%0d ctl=%b",
                   tag, state, ctl, es, ec);
        end
    endtask

    initial begin
        rst  = 1'b1;
        code = 3'd0;

        // Reset
        step();
        chk("rst_held", 3'd0, C_NONE);
        rst = 1'b0;
        #1;
        chk("fetch_after_rst", 3'd0, C_FETCH);

        // ALU: code changed after DECODE must be ignored
        code = 3'd0;
        step(); chk("alu_decode", 3'd1, C_NONE);
        step(); code = 3'd3; #1;
        chk("alu_exec", 3'd2, C_EX_ALU);
        step(); chk("alu_wb", 3'd4, C_WB_ALU);
        step(); chk("alu_fetch", 3'd0, C_FETCH);

        // ALUI
        code = 3'd1;
        step(); chk("alui_decode", 3'd1, C_NONE);
        step(); chk("alui_exec", 3'd2, C_EX_IMM);
        step(); chk("alui_wb", 3'd4, C_WB_IMM);
        step(); chk("alui_fetch", 3'd0, C_FETCH);

        // LOAD
        code = 3'd2;
        step(); chk("ld_decode", 3'd1, C_NONE);
        step(); chk("ld_exec", 3'd2, C_EX_IMM);
        step(); chk("ld_mem", 3'd3, C_MEM_LD);
        step(); chk("ld_wb", 3'd4, C_WB_LD);
        step(); chk("ld_fetch", 3'd0, C_FETCH);

        // STORE
        code = 3'd3;
        step(); chk("st_decode", 3'd1, C_NONE);
        step(); chk("st_exec", 3'd2, C_EX_IMM);
        step(); chk("st_mem", 3'd3, C_MEM_ST);
        step(); chk("st_fetch", 3'd0, C_FETCH);

        // BRANCH
        code = 3'd4;
        step(); chk("br_decode", 3'd1, C_NONE);
        step(); chk("br_exec", 3'd2, C_EX_BR);
        step(); chk("br_fetch", 3'd0, C_FETCH);

        // JUMP
        code = 3'd5;
        step(); chk("jmp_decode", 3'd1, C_NONE);
        step(); chk("jmp_exec", 3'd2, C_EX_JMP);
        step(); chk("jmp_fetch", 3'd0, C_FETCH);

        // NOP
        code = 3'd6;
        step(); chk("nop_decode", 3'd1, C_NONE);
        step(); chk("nop_fetch", 3'd0, C_FETCH);

        // Opcode changing every clock: only the DECODE value counts.
        code = 3'd0;
        step(); code = 3'd1; #1; chk("walk_decode1", 3'd1, C_NONE);
        step(); code = 3'd2; #1; chk("walk_exec_alui", 3'd2, C_EX_IMM);
        step(); code = 3'd3; #1; chk("walk_wb_alui", 3'd4, C_WB_IMM);
        step(); code = 3'd4; #1; chk("walk_fetch1", 3'd0, C_FETCH);
        step(); code = 3'd5; #1; chk("walk_decode2", 3'd1, C_NONE);
        step(); code = 3'd6; #1; chk("walk_exec_jmp", 3'd2, C_EX_JMP);
        step(); code = 3'd7; #1; chk("walk_fetch2", 3'd0, C_FETCH);
        step(); code = 3'd4; #1; chk("walk_decode3", 3'd1, C_NONE);
        step(); code = 3'd0; #1; chk("walk_exec_br", 3'd2, C_EX_BR);
        step(); chk("walk_fetch3", 3'd0, C_FETCH);

        // Reset in the middle of a LOAD
        code = 3'd2;
        step(); step(); step();
        chk("ld2_mem", 3'd3, C_MEM_LD);
        rst = 1'b1; #1;
        chk("mid_rst_gated", 3'd3, C_NONE);
        step(); chk("mid_rst_state", 3'd0, C_NONE);
        rst = 1'b0; #1;
        chk("mid_rst_fetch", 3'd0, C_FETCH);

        // HALT
        code = 3'd7;
        step(); chk("halt_decode", 3'd1, C_NONE);
        step(); code = 3'd0; #1; chk("halt_enter", 3'd5, C_HALT);
        for (int i = 0; i < 4; i++) begin
            step();
            code = 3'(i + 1);
        end
        #1;
        chk("halt_stays", 3'd5, C_HALT);
        rst = 1'b1; #1;
        chk("halt_rst_gated", 3'd5, C_NONE);
        step(); chk("halt_rst_state", 3'd0, C_NONE);
        rst = 1'b0; #1;
        chk("halt_exit_fetch", 3'd0, C_FETCH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
